// File: rtl/sort4_stream.sv
// rtl/sort4_stream.sv - serial-in/serial-out 4-word descending sorter, one compare-exchange per clock
// Optional SORT4_IDX_EN: carries a 2-bit arrival-index tag with every element and exposes it on out_idx.
module sort4_stream #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
`ifdef SORT4_IDX_EN
    ,
    output logic [1:0]   out_idx
`endif
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t       state, state_nxt;
    logic [1:0]   cnt, cnt_nxt;
    logic [2:0]   step, step_nxt;
    logic [W-1:0] v [4];
    logic [W-1:0] v_nxt [4];
    logic [1:0]   ex_a, ex_b;
    logic         in_ready_nxt, out_valid_nxt, out_last_nxt, busy_nxt;
    logic [W-1:0] out_data_nxt;
`ifdef SORT4_IDX_EN
    logic [1:0]   tag [4];
    logic [1:0]   tag_nxt [4];
    logic [1:0]   out_idx_nxt;
`endif

    // Network order: (0,2) (1,3) (0,1) (2,3) (1,2)
    always_comb begin
        case (step)
            3'd0:    begin ex_a = 2'd0; ex_b = 2'd2; end
            3'd1:    begin ex_a = 2'd1; ex_b = 2'd3; end
            3'd2:    begin ex_a = 2'd0; ex_b = 2'd1; end
            3'd3:    begin ex_a = 2'd2; ex_b = 2'd3; end
            default: begin ex_a = 2'd1; ex_b = 2'd2; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_LOAD;
            cnt       <= 2'd0;
            step      <= 3'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < 4; i++) begin
                v[i] <= '0;
            end
`ifdef SORT4_IDX_EN
            out_idx <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                tag[i] <= 2'd0;
            end
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            step      <= step_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            out_last  <= out_last_nxt;
            busy      <= busy_nxt;
            out_data  <= out_data_nxt;
            for (int i = 0; i < 4; i++) begin
                v[i] <= v_nxt[i];
            end
`ifdef SORT4_IDX_EN
            out_idx <= out_idx_nxt;
            for (int i = 0; i < 4; i++) begin
                tag[i] <= tag_nxt[i];
            end
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        step_nxt  = step;
        for (int i = 0; i < 4; i++) begin
            v_nxt[i] = v[i];
        end
`ifdef SORT4_IDX_EN
        for (int i = 0; i < 4; i++) begin
            tag_nxt[i] = tag[i];
        end
`endif
        case (state)
            ST_LOAD: begin
                if (in_valid && in_ready) begin
                    v_nxt[cnt] = in_data;
`ifdef SORT4_IDX_EN
                    tag_nxt[cnt] = cnt;
`endif
                    if (cnt == 2'd3) begin
                        state_nxt = ST_SORT;
                        step_nxt  = 3'd0;
                        cnt_nxt   = 2'd0;
                    end else begin
                        cnt_nxt = cnt + 2'd1;
                    end
                end
            end
            ST_SORT: begin
                // Strict compare keeps equal keys (and their tags) in place
                if (v[ex_a] < v[ex_b]) begin
                    v_nxt[ex_a] = v[ex_b];
                    v_nxt[ex_b] = v[ex_a];
`ifdef SORT4_IDX_EN
                    tag_nxt[ex_a] = tag[ex_b];
                    tag_nxt[ex_b] = tag[ex_a];
`endif
                end
                if (step == 3'd4) begin
                    state_nxt = ST_DRAIN;
                    step_nxt  = 3'd0;
                    cnt_nxt   = 2'd0;
                end else begin
                    step_nxt = step + 3'd1;
                end
            end
            ST_DRAIN: begin
                if (out_valid && out_ready) begin
                    if (cnt == 2'd3) begin
                        state_nxt = ST_LOAD;
                        cnt_nxt   = 2'd0;
                    end else begin
                        cnt_nxt = cnt + 2'd1;
                    end
                end
            end
            default: begin
                state_nxt = ST_LOAD;
                cnt_nxt   = 2'd0;
                step_nxt  = 3'd0;
            end
        endcase
    end

    // Outputs are decoded from next-state values and then flopped, so every port is a register
    always_comb begin
        in_ready_nxt  = (state_nxt == ST_LOAD);
        out_valid_nxt = (state_nxt == ST_DRAIN);
        busy_nxt      = (state_nxt != ST_LOAD);
        out_last_nxt  = (state_nxt == ST_DRAIN) && (cnt_nxt == 2'd3);
        out_data_nxt  = (state_nxt == ST_DRAIN) ? v_nxt[cnt_nxt] : '0;
`ifdef SORT4_IDX_EN
        out_idx_nxt   = (state_nxt == ST_DRAIN) ? tag_nxt[cnt_nxt] : 2'd0;
`endif
    end

endmodule

// File: tb/tb_sort4_stream.sv
// tb/tb_sort4_stream.sv - self-checking bench for sort4_stream (build with +define+SORT4_IDX_EN for tag checks)
module tb_sort4_stream;
    localparam int W = 4;
    localparam int PA [5] = '{0, 1, 0, 2, 1};
    localparam int PB [5] = '{2, 3, 1, 3, 2};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         busy;
    logic [1:0]   out_idx_s;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [3:0] blk [4];
    logic [3:0] exp_d [4];
    logic [1:0] exp_i [4];
    logic [3:0] got_d [4];
    logic [1:0] got_i [4];
    logic       got_l [4];
    int nbeats, first_v, unstable, drain_bad, acc_cyc;
    bit tmo_in, tmo_out;

`ifdef SORT4_IDX_EN
    logic [1:0] out_idx;
    assign out_idx_s = out_idx;
`else
    assign out_idx_s = 2'd0;
`endif

    sort4_stream #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
`ifdef SORT4_IDX_EN
        ,
        .out_idx   (out_idx)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain descending sort for data; tags follow the compare-exchange list
    task automatic compute_expect();
        logic [3:0] d [4];
        logic [3:0] tv [4];
        logic [1:0] tt [4];
        logic [3:0] x;
        logic [1:0] y;
        for (int i = 0; i < 4; i++) begin
            d[i] = blk[i];
            tv[i] = blk[i];
            tt[i] = 2'(i);
        end
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (d[j] > d[i]) begin x = d[i]; d[i] = d[j]; d[j] = x; end
        for (int s = 0; s < 5; s++)
            if (tv[PA[s]] < tv[PB[s]]) begin
                x = tv[PA[s]]; tv[PA[s]] = tv[PB[s]]; tv[PB[s]] = x;
                y = tt[PA[s]]; tt[PA[s]] = tt[PB[s]]; tt[PB[s]] = y;
            end
        for (int i = 0; i < 4; i++) begin
            exp_d[i] = d[i];
            exp_i[i] = tt[i];
        end
    endtask

    task automatic send4();
        int g;
        tmo_in = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = blk[k];
            g = 0;
            while (!in_ready && g < 100) begin
                @(negedge clk);
                g++;
            end
            if (g >= 100) tmo_in = 1;
            @(posedge clk);
        end
        #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: toggle starting high, 2: random
    task automatic collect(input int mode);
        int g;
        bit pv, pr;
        logic [3:0] pd;
        nbeats = 0; first_v = -1; unstable = 0; drain_bad = 0; tmo_out = 0;
        pv = 0; pr = 0; pd = 0; g = 0;
        out_ready = 1'b0;
        while (nbeats < 4 && g < 300) begin
            @(negedge clk);
            g++;
            if (out_valid && first_v < 0) first_v = cyc;
            if (pv && !pr && (!out_valid || out_data !== pd)) unstable++;
            if (first_v >= 0 && (in_ready || !busy)) drain_bad++;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid && out_ready) begin
                got_d[nbeats] = out_data;
                got_i[nbeats] = out_idx_s;
                got_l[nbeats] = out_last;
                nbeats++;
            end
            pv = out_valid; pr = out_ready; pd = out_data;
        end
        if (nbeats < 4) tmo_out = 1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0 || out_last !== 1'b0) begin bad++; $display("FAIL reset_busy_last got=%b%b want=00", busy, out_last); end
        total++; if (out_data !== 4'h0 || out_idx_s !== 2'd0) begin bad++; $display("FAIL reset_data got=%h/%0d want=0/0", out_data, out_idx_s); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] e [4];
        e = '{4'h9, 4'h7, 4'h3, 4'h1};
        blk = '{4'h3, 4'h9, 4'h1, 4'h7};
        send4();
        @(negedge clk);
        total++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL basic_sort_flags got busy=%b rdy=%b vld=%b want 1,0,0", busy, in_ready, out_valid); end
        collect(0);
        total++; if (tmo_in || tmo_out) begin bad++; $display("FAIL basic_timeout got in=%0d out=%0d want 0,0", tmo_in, tmo_out); end
        total++; if (first_v !== acc_cyc + 5) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", first_v - acc_cyc, 5); end
        for (int k = 0; k < 4; k++) begin
            total++; if (got_d[k] !== e[k] || got_l[k] !== (k == 3)) begin bad++; $display("FAIL basic_beat%0d got=%h last=%b want=%h last=%b", k, got_d[k], got_l[k], e[k], k == 3); end
        end
    endtask

    task automatic test_ties_and_reverse();
        logic [1:0] ti [4];
        blk = '{4'h5, 4'h5, 4'h5, 4'h5};
        send4();
        collect(0);
        for (int k = 0; k < 4; k++) begin
            total++; if (got_d[k] !== 4'h5) begin bad++; $display("FAIL ties_beat%0d got=%h want=5", k, got_d[k]); end
`ifdef SORT4_IDX_EN
            total++; if (got_i[k] !== 2'(k)) begin bad++; $display("FAIL ties_idx%0d got=%0d want=%0d", k, got_i[k], k); end
`endif
        end
        blk = '{4'h1, 4'h2, 4'h3, 4'h4};
        ti = '{2'd3, 2'd2, 2'd1, 2'd0};
        send4();
        collect(0);
        for (int k = 0; k < 4; k++) begin
            total++; if (got_d[k] !== 4'(4 - k)) begin bad++; $display("FAIL rev_beat%0d got=%h want=%h", k, got_d[k], 4 - k); end
`ifdef SORT4_IDX_EN
            total++; if (got_i[k] !== ti[k]) begin bad++; $display("FAIL rev_idx%0d got=%0d want=%0d", k, got_i[k], ti[k]); end
`endif
        end
        total++; if (tmo_out) begin bad++; $display("FAIL rev_timeout got=1 want=0"); end
    endtask

    task automatic test_stall();
        logic [3:0] e [4];
        e = '{4'hF, 4'hF, 4'h0, 4'h0};
        blk = '{4'h0, 4'hF, 4'h0, 4'hF};
        compute_expect();
        send4();
        collect(1);
        total++; if (unstable !== 0) begin bad++; $display("FAIL stall_hold got=%0d want=0", unstable); end
        total++; if (drain_bad !== 0) begin bad++; $display("FAIL stall_in_ready got=%0d want=0", drain_bad); end
        for (int k = 0; k < 4; k++) begin
            total++; if (got_d[k] !== e[k] || got_l[k] !== (k == 3)) begin bad++; $display("FAIL stall_beat%0d got=%h last=%b want=%h", k, got_d[k], got_l[k], e[k]); end
`ifdef SORT4_IDX_EN
            total++; if (got_i[k] !== exp_i[k]) begin bad++; $display("FAIL stall_idx%0d got=%0d want=%0d", k, got_i[k], exp_i[k]); end
`endif
        end
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_ready_after got=%b want=1", in_ready); end
    endtask

    task automatic test_ignore_input();
        logic [3:0] e1 [4];
        logic [3:0] e2 [4];
        e1 = '{4'h6, 4'h4, 4'h2, 4'h1};
        e2 = '{4'h5, 4'h3, 4'h1, 4'h0};
        blk = '{4'h2, 4'h6, 4'h4, 4'h1};
        send4();
        in_valid = 1'b1;
        in_data = 4'hA;
        collect(2);
        for (int k = 0; k < 4; k++) begin
            total++; if (got_d[k] !== e1[k]) begin bad++; $display("FAIL ignore_blk1_beat%0d got=%h want=%h", k, got_d[k], e1[k]); end
        end
        blk = '{4'h3, 4'h0, 4'h5, 4'h1};
        send4();
        collect(0);
        for (int k = 0; k < 4; k++) begin
            total++; if (got_d[k] !== e2[k]) begin bad++; $display("FAIL ignore_blk2_beat%0d got=%h want=%h", k, got_d[k], e2[k]); end
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        blk = '{4'h8, 4'h2, 4'h6, 4'h4};
        send4();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin bad++; $display("FAIL midrst_flags got rdy=%b vld=%b busy=%b last=%b want 1,0,0,0", in_ready, out_valid, busy, out_last); end
        total++; if (out_data !== 4'h0 || out_idx_s !== 2'd0) begin bad++; $display("FAIL midrst_data got=%h/%0d want=0/0", out_data, out_idx_s); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_output got=%0d want=0", seen); end
        blk = '{4'h1, 4'h3, 4'h2, 4'h0};
        send4();
        collect(0);
        for (int k = 0; k < 4; k++) begin
            total++; if (got_d[k] !== 4'(3 - k)) begin bad++; $display("FAIL midrst_beat%0d got=%h want=%h", k, got_d[k], 3 - k); end
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 25; b++) begin
            for (int i = 0; i < 4; i++) blk[i] = 4'($urandom_range(0, 15));
            if (b == 0) blk = '{4'hF, 4'hF, 4'hF, 4'hF};
            compute_expect();
            send4();
            collect(b % 3);
            total++; if (tmo_in || tmo_out || first_v !== acc_cyc + 5) begin bad++; $display("FAIL rand%0d_latency got=%0d tmo=%0d%0d want=5", b, first_v - acc_cyc, tmo_in, tmo_out); end
            total++; if (unstable !== 0 || drain_bad !== 0) begin bad++; $display("FAIL rand%0d_hold got=%0d/%0d want=0/0", b, unstable, drain_bad); end
            for (int k = 0; k < 4; k++) begin
                total++; if (got_d[k] !== exp_d[k] || got_l[k] !== (k == 3)) begin bad++; $display("FAIL rand%0d_beat%0d got=%h last=%b want=%h", b, k, got_d[k], got_l[k], exp_d[k]); end
`ifdef SORT4_IDX_EN
                total++; if (got_i[k] !== exp_i[k]) begin bad++; $display("FAIL rand%0d_idx%0d got=%0d want=%0d", b, k, got_i[k], exp_i[k]); end
`endif
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_ties_and_reverse();
        test_stall();
        test_ignore_input();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
